// File: rtl/part_prio_encoder_ack.sv
// Registered 8-to-3 priority encoder: latches active-low requests, grants the highest
// eligible index and holds the code until the consumer acknowledges it.
module part_prio_encoder_ack #(
  parameter int unsigned N_REQ  = 8,
  parameter int unsigned CODE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_n,
  input  logic [N_REQ-1:0]  mask,
  input  logic              ei_n,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pend,
  output logic              gs_n,
  output logic              eo_n
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StPresent = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [N_REQ-1:0]  pend_d;
  logic [CODE_W-1:0] code_d;
  logic              valid_d;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  clr;
  logic [CODE_W-1:0] winner;

  assign elig = pend & mask;

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (elig[i]) winner = CODE_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state_q == StPresent && ack) clr[code] = 1'b1;
  end

  // New requests are ORed in after the clear, so a re-asserting line stays pending.
  assign pend_d = (pend & ~clr) | (~req_n & mask);

  always_comb begin
    state_d = state_q;
    code_d  = code;
    valid_d = valid;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (!ei_n && (elig != '0)) begin
          code_d  = winner;
          valid_d = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pend    <= '0;
      code    <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend    <= pend_d;
      code    <= code_d;
      valid   <= valid_d;
    end
  end

  // Cascade outputs: eo_n of a higher bank feeds ei_n of the next lower bank.
  assign gs_n = (pend == '0);
  assign eo_n = !(!ei_n && (pend == '0));

endmodule
